cell_pos_streamer: RTL and testbench

- Read-side sequencer placed directly downstream of one position cell memory.
- On a start pulse it reads the particle count from address 0, then reads addresses 1..count.
- It emits each 96-bit {posz,posy,posx} word on a valid/ready stream toward the force-evaluation filter.
- It hides the memory's 2-cycle read latency and absorbs downstream backpressure with a small credit-controlled FIFO.

---
 rtl/cell_pos_streamer.sv | 184 ++++++++++++++++++
 tb/tb_cell_pos_streamer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_pos_streamer.sv
`default_nettype none
// ============================================================================
// Module   : cell_pos_streamer
// Brief    : Reads a particle count and then positions 1..count from a cell
//            memory with 2-cycle read latency, and streams them on valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module cell_pos_streamer #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pos,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last,
    output logic [ADDR_WIDTH-1:0] particle_cnt
);

    localparam int                    PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                    OCC_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT   = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [OCC_W:0]        DEPTH_SUM = (OCC_W + 1)'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0]      DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    generate
        if (FIFO_DEPTH < 3) begin : g_depth_check
            $error("FIFO_DEPTH must be at least 3");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_CNT   = 3'd1,
        S_WAIT_CNT = 3'd2,
        S_STREAM   = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                state, next_state;
    logic                  wait_second;
    logic [ADDR_WIDTH-1:0] rd_ptr, cnt_reg, addr_hold;
    logic                  s1_valid, s2_valid;
    logic [ADDR_WIDTH-1:0] s1_pid, s2_pid;
    logic                  last_sent;

    logic [DATA_WIDTH-1:0] fifo_pos  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pid  [FIFO_DEPTH];
    logic                  fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_idx, rd_idx;
    logic [OCC_W-1:0]      occ;

    logic                  cnt_read, issue, push, pop;
    logic [ADDR_WIDTH-1:0] cnt_raw, cnt_clamped;
    logic [1:0]            inflight;
    logic [OCC_W:0]        credit_sum;
    logic                  credit_ok;

    assign cnt_raw     = mem_q[ADDR_WIDTH-1:0];
    assign cnt_clamped = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;
    assign inflight    = {1'b0, s1_valid} + {1'b0, s2_valid};
    // Reads already in flight hold a FIFO slot in reserve, so the buffer cannot overflow.
    assign credit_sum  = (OCC_W + 1)'(occ) + (OCC_W + 1)'(inflight);
    assign credit_ok   = credit_sum < DEPTH_SUM;
    assign push        = s2_valid;
    assign pop         = out_valid && out_ready;

    always_comb begin
        next_state = state;
        cnt_read   = 1'b0;
        issue      = 1'b0;
        case (state)
            S_IDLE:     if (start) next_state = S_RD_CNT;
            S_RD_CNT: begin
                cnt_read   = 1'b1;
                next_state = S_WAIT_CNT;
            end
            S_WAIT_CNT: if (wait_second) next_state = (cnt_clamped == '0) ? S_DONE : S_STREAM;
            S_STREAM: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (rd_ptr == cnt_reg) next_state = S_DRAIN;
                end
            end
            S_DRAIN:    if (inflight == 2'd0 && (last_sent || (pop && out_last))) next_state = S_DONE;
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    assign mem_rden     = cnt_read | issue;
    assign mem_address  = cnt_read ? '0 : (issue ? rd_ptr : addr_hold);
    assign mem_wren     = 1'b0;
    assign mem_data     = '0;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign particle_cnt = cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_second <= 1'b0;
            rd_ptr      <= '0;
            cnt_reg     <= '0;
            addr_hold   <= '0;
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            s1_pid      <= '0;
            s2_pid      <= '0;
            last_sent   <= 1'b0;
        end else begin
            state       <= next_state;
            wait_second <= (state == S_WAIT_CNT) ? ~wait_second : 1'b0;
            addr_hold   <= mem_address;
            s1_valid    <= issue;
            s1_pid      <= rd_ptr;
            s2_valid    <= s1_valid;
            s2_pid      <= s1_pid;
            if (state == S_WAIT_CNT && wait_second) begin
                cnt_reg <= cnt_clamped;
                rd_ptr  <= ADDR_WIDTH'(1);
            end else if (issue && rd_ptr != cnt_reg) begin
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (state == S_RD_CNT)    last_sent <= 1'b0;
            else if (pop && out_last) last_sent <= 1'b1;
        end
    end

    // First-word-fall-through buffer: head entry is presented whenever occupancy is non-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_idx <= (wr_idx == LAST_PTR) ? '0 : wr_idx + 1'b1;
            if (pop)  rd_idx <= (rd_idx == LAST_PTR) ? '0 : rd_idx + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pos[wr_idx]  <= mem_q;
            fifo_pid[wr_idx]  <= s2_pid;
            fifo_last[wr_idx] <= (s2_pid == cnt_reg);
        end
    end

    assign out_valid = (occ != '0);
    assign out_pos   = out_valid ? fifo_pos[rd_idx]  : '0;
    assign out_pid   = out_valid ? fifo_pid[rd_idx]  : '0;
    assign out_last  = out_valid ? fifo_last[rd_idx] : 1'b0;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && occ == DEPTH_OCC))
                else $error("cell_pos_streamer: output buffer overflow");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cell_pos_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_pos_streamer
// Brief    : Scoreboard bench for cell_pos_streamer with a 2-cycle memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cell_pos_streamer;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int FD = 4;

    typedef struct packed {
        logic [DW-1:0] pos;
        logic [AW-1:0] pid;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, mem_rden, mem_wren, out_valid, out_last;
    logic [AW-1:0] mem_address, out_pid, particle_cnt;
    logic [DW-1:0] mem_data, out_pos;
    logic [DW-1:0] mem_q = '0;
    logic [DW-1:0] rd_pipe = '0;
    logic [DW-1:0] mem [0:255];

    int   checks = 0, failures = 0, cyc = 0, s_cyc = 0, scan_cnt = 0;
    int   done_cnt, done_cyc, first_valid_cyc, last_xfer_cyc, xfer_cnt, rd_cnt, issued, stall_low;
    logic [AW-1:0] last_rd_addr;
    exp_t exp_q[$];
    exp_t e;
    logic prev_stall = 1'b0;
    exp_t prev_word;

    cell_pos_streamer #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_data(mem_data),
        .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
        .out_pid(out_pid), .out_last(out_last), .particle_cnt(particle_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data appears on mem_q two cycles after the read-enable cycle.
    always @(posedge clk) begin
        if (mem_rden) rd_pipe <= mem[mem_address];
        mem_q <= rd_pipe;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (mem_rden) begin
                rd_cnt++;
                last_rd_addr = mem_address;
                if (mem_address != '0) issued++;
                checks++;
                if (issued - xfer_cnt > FD) begin
                    failures++;
                    $display("FAIL credit: outstanding=%0d limit=%0d", issued - xfer_cnt, FD);
                end
            end else if (busy && issued > 0 && issued < scan_cnt) begin
                stall_low++;
            end
            if (prev_stall) begin
                checks++;
                if (!out_valid || {out_pos, out_pid, out_last} !== prev_word) begin
                    failures++;
                    $display("FAIL hold: valid=%0b pid=%0d expected held pid=%0d", out_valid, out_pid, prev_word.pid);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL xfer_extra: got pid=%0d expected no transfer", out_pid);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_pos, out_pid, out_last} !== e) begin
                        failures++;
                        $display("FAIL xfer: got pid=%0d last=%0b pos=%h expected pid=%0d last=%0b pos=%h",
                                 out_pid, out_last, out_pos, e.pid, e.last, e.pos);
                    end
                end
                xfer_cnt++;
                last_xfer_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_pos, out_pid, out_last};
        end
    end

    task automatic clear_stats();
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; last_xfer_cyc = -1;
        xfer_cnt = 0; rd_cnt = 0; issued = 0; stall_low = 0; last_rd_addr = '0;
        exp_q.delete();
    endtask

    task automatic load_scan(input logic [DW-1:0] word0, input int n);
        exp_t x;
        mem[0] = word0;
        scan_cnt = n;
        for (int i = 1; i <= n; i++) begin
            mem[i] = {$urandom, $urandom, $urandom};
            x.pos = mem[i]; x.pid = AW'(i); x.last = (i == n);
            exp_q.push_back(x);
        end
    endtask

    task automatic start_scan();
        @(posedge clk); #1;
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_ctl: busy=%0b done=%0b expected 0 0", busy, done); end
        checks++; if (mem_rden !== 1'b0 || mem_address !== '0) begin failures++; $display("FAIL reset_mem: rden=%0b addr=%0d expected 0 0", mem_rden, mem_address); end
        checks++; if (mem_wren !== 1'b0 || mem_data !== '0) begin failures++; $display("FAIL reset_wr: wren=%0b data=%h expected 0 0", mem_wren, mem_data); end
        checks++; if (out_valid !== 1'b0 || out_pos !== '0 || out_pid !== '0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_out: valid=%0b pid=%0d expected 0 0", out_valid, out_pid); end
        checks++; if (particle_cnt !== '0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", particle_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_count5();
        clear_stats();
        load_scan(96'd5, 5);
        out_ready = 1'b1;
        start_scan();
        wait_done(60);
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL c5_done: got %0d expected 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL c5_busy_after: got %0b expected 0", busy); end
        checks++; if (first_valid_cyc - s_cyc != 7) begin failures++; $display("FAIL c5_latency: got %0d expected 7", first_valid_cyc - s_cyc); end
        checks++; if (last_xfer_cyc - s_cyc != 11) begin failures++; $display("FAIL c5_last_xfer: got %0d expected 11", last_xfer_cyc - s_cyc); end
        checks++; if (done_cyc - s_cyc != 12) begin failures++; $display("FAIL c5_done_cyc: got %0d expected 12", done_cyc - s_cyc); end
        checks++; if (xfer_cnt != 5 || exp_q.size() != 0) begin failures++; $display("FAIL c5_count: got %0d left %0d expected 5 0", xfer_cnt, exp_q.size()); end
        checks++; if (particle_cnt !== 8'd5 || rd_cnt != 6) begin failures++; $display("FAIL c5_cnt: got cnt=%0d reads=%0d expected 5 6", particle_cnt, rd_cnt); end
    endtask

    task automatic test_count0();
        clear_stats();
        load_scan({88'h5A5A_5A5A_5A5A_5A5A_5A5A_5A, 8'h00}, 0);
        start_scan();
        wait_done(40);
        checks++; if (done_cnt != 1 || done_cyc - s_cyc != 4) begin failures++; $display("FAIL c0_done: got n=%0d at %0d expected 1 at 4", done_cnt, done_cyc - s_cyc); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL c0_busy_after: got %0b expected 0", busy); end
        checks++; if (rd_cnt != 1 || last_rd_addr !== '0) begin failures++; $display("FAIL c0_reads: got %0d addr %0d expected 1 0", rd_cnt, last_rd_addr); end
        checks++; if (first_valid_cyc != -1 || particle_cnt !== '0) begin failures++; $display("FAIL c0_out: got valid_cyc=%0d cnt=%0d expected -1 0", first_valid_cyc, particle_cnt); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        clear_stats();
        load_scan(96'd20, 20);
        out_ready = 1'b0;
        start_scan();
        while (done_cnt == 0 && n < 800) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 99) < 30);
            n++;
        end
        out_ready = 1'b1;
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
        checks++; if (xfer_cnt != 20 || exp_q.size() != 0) begin failures++; $display("FAIL bp_count: got %0d left %0d expected 20 0", xfer_cnt, exp_q.size()); end
        checks++; if (stall_low == 0) begin failures++; $display("FAIL bp_rden_stall: got %0d stalled cycles expected >0", stall_low); end
        checks++; if (particle_cnt !== 8'd20) begin failures++; $display("FAIL bp_cnt: got %0d expected 20", particle_cnt); end
    endtask

    task automatic test_clamp();
        clear_stats();
        load_scan({88'hDEAD_BEEF_0000_1234_5678_9A, 8'hFF}, PN - 1);
        out_ready = 1'b1;
        start_scan();
        wait_done(400);
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL clamp_done: got %0d expected 1", done_cnt); end
        checks++; if (particle_cnt !== 8'd219) begin failures++; $display("FAIL clamp_cnt: got %0d expected 219", particle_cnt); end
        checks++; if (last_rd_addr !== 8'd219 || rd_cnt != 220) begin failures++; $display("FAIL clamp_reads: got addr %0d n %0d expected 219 220", last_rd_addr, rd_cnt); end
        checks++; if (xfer_cnt != 219 || exp_q.size() != 0) begin failures++; $display("FAIL clamp_count: got %0d left %0d expected 219 0", xfer_cnt, exp_q.size()); end
    endtask

    task automatic test_start_while_busy();
        clear_stats();
        load_scan(96'd20, 20);
        out_ready = 1'b1;
        start_scan();
        while (cyc < s_cyc + 10) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL swb_busy: got %0b expected 1", busy); end
        wait_done(100);
        repeat (30) @(posedge clk);
        #1;
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL swb_done: got %0d expected 1", done_cnt); end
        checks++; if (xfer_cnt != 20 || exp_q.size() != 0 || rd_cnt != 21) begin failures++; $display("FAIL swb_count: got %0d reads %0d expected 20 21", xfer_cnt, rd_cnt); end
    endtask

    task automatic test_reset_mid_scan();
        clear_stats();
        load_scan(96'd10, 10);
        out_ready = 1'b0;
        start_scan();
        while (cyc < s_cyc + 8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || mem_rden !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmid_ctl: busy=%0b valid=%0b rden=%0b expected 0 0 0", busy, out_valid, mem_rden); end
        checks++; if (out_pos !== '0 || out_pid !== '0 || particle_cnt !== '0 || mem_address !== '0) begin failures++; $display("FAIL rmid_data: pid=%0d cnt=%0d addr=%0d expected 0 0 0", out_pid, particle_cnt, mem_address); end
        repeat (2) @(posedge clk);
        #1;
        clear_stats();
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        load_scan(96'd3, 3);
        out_ready = 1'b1;
        start_scan();
        wait_done(60);
        checks++; if (done_cnt != 1 || xfer_cnt != 3 || exp_q.size() != 0) begin failures++; $display("FAIL rmid_rescan: got done=%0d xfers=%0d expected 1 3", done_cnt, xfer_cnt); end
        checks++; if (first_valid_cyc - s_cyc != 7 || particle_cnt !== 8'd3) begin failures++; $display("FAIL rmid_stale: got first=%0d cnt=%0d expected 7 3", first_valid_cyc - s_cyc, particle_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
        clear_stats();
        test_reset();
        test_count5();
        test_count0();
        test_backpressure();
        test_clamp();
        test_start_while_busy();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
